// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Small sequential ALU. Single-cycle operations (ADD, SUB, AND, OR, NOT, INC,
//   PASS) complete at the edge that accepts them. MUL is an unsigned
//   shift-add multiply that takes WIDTH cycles after acceptance.
//
// Ports
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      asynchronous active-high reset
//   start      in   1      request one operation, sampled only in IDLE
//   operation  in   3      opcode (see op_t)
//   operand1   in   WIDTH  first operand (multiplicand for MUL)
//   operand2   in   WIDTH  second operand (multiplier for MUL)
//   flags_we   in   1      load flag register from flags_in (context restore)
//   flags_in   in   4      flag value to load; bit3 is ignored
//   result     out  WIDTH  registered result of last completed operation
//   flags_out  out  4      {0, C, N, Z}
//   busy       out  1      multiply in progress
//   done       out  1      one-cycle completion pulse
//
// Handshake: start is a request qualified only while the FSM is IDLE (busy=0);
// anything presented on start/operation/operands while busy=1 is ignored.
// Every accepted operation produces exactly one done pulse in the cycle after
// its result is written, unless reset aborts it first.
//
// FSM state is visible internally as 'state' (state_t) for checker binding.
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             flags_we,
  input  logic [3:0]       flags_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_NOT  = 3'b100,
    OP_INC  = 3'b101,
    OP_MUL  = 3'b110,
    OP_PASS = 3'b111
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Multiply datapath: acc holds {partial_high, remaining_multiplier}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   step_cnt;

  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic               last_step;

  // Single-cycle ALU.
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH:0]     inc_full;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;

  // Control.
  logic               accept_single;
  logic               accept_mul;
  logic               complete;
  logic [WIDTH-1:0]   res_next;
  logic               c_next;
  logic [3:0]         flags_calc;

  // flags_in[3] has no meaning: the stored bit3 is always zero.
  logic               unused_flag_bit;
  assign unused_flag_bit = flags_in[3];

  // ---------------------------------------------------------------------------
  // Single-cycle arithmetic. The extra top bit captures carry / borrow.
  // ---------------------------------------------------------------------------
  assign add_full = {1'b0, operand1} + {1'b0, operand2};
  assign sub_full = {1'b0, operand1} - {1'b0, operand2};
  assign inc_full = {1'b0, operand1} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = operand1;
    alu_c   = flags_out[2];   // logical ops keep the previous carry
    case (op_t'(operation))
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];   // borrow: op1 < op2 unsigned
      end
      OP_AND:  alu_res = operand1 & operand2;
      OP_OR:   alu_res = operand1 | operand2;
      OP_NOT:  alu_res = ~operand1;
      OP_INC: begin
        alu_res = inc_full[WIDTH-1:0];
        alu_c   = inc_full[WIDTH];
      end
      OP_PASS: alu_res = operand1;
      default: alu_res = operand1;   // OP_MUL never completes here
    endcase
  end

  // ---------------------------------------------------------------------------
  // One shift-add step: if the current multiplier LSB is set, add the
  // multiplicand into the high half (keeping its carry), then shift the whole
  // accumulator right. After WIDTH steps acc holds the full product.
  // ---------------------------------------------------------------------------
  always_comb begin
    step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_step = {step_sum, acc[WIDTH-1:1]};
  end

  assign last_step = (state == S_MUL) && (step_cnt == CNT_W'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start && (op_t'(operation) == OP_MUL)) state_next = S_MUL;
      S_MUL:  if (last_step) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and per-edge control decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    busy          = (state == S_MUL);
    accept_single = (state == S_IDLE) && start && (op_t'(operation) != OP_MUL);
    accept_mul    = (state == S_IDLE) && start && (op_t'(operation) == OP_MUL);
    complete      = accept_single || last_step;

    res_next = alu_res;
    c_next   = alu_c;
    if (last_step) begin
      res_next = acc_step[WIDTH-1:0];
      c_next   = |acc_step[2*WIDTH-1:WIDTH];   // product overflowed WIDTH bits
    end
    flags_calc = {1'b0, c_next, res_next[WIDTH-1], (res_next == '0)};
  end

  // ---------------------------------------------------------------------------
  // Result, flags, done pulse and multiply datapath registers.
  // A completing operation owns the flag register on its edge; flags_we only
  // takes effect on edges where nothing completes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      flags_out <= '0;
      done      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      step_cnt  <= '0;
    end else begin
      done <= complete;

      if (complete) begin
        result    <= res_next;
        flags_out <= flags_calc;
      end else if (flags_we) begin
        flags_out <= {1'b0, flags_in[2:0]};
      end

      if (accept_mul) begin
        // Operands are captured here so later input changes cannot disturb
        // the running product.
        acc      <= {{WIDTH{1'b0}}, operand2};
        mcand    <= operand1;
        step_cnt <= '0;
      end else if (state == S_MUL) begin
        acc      <= acc_step;
        step_cnt <= step_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Self-checking bench for seq_alu (WIDTH=16). Expected results come from a
//   plain-arithmetic model of the opcode table; directed cases cover the
//   documented corner values, followed by randomized operations.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   operation;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic         flags_we;
  logic [3:0]   flags_in;
  logic [W-1:0] result;
  logic [3:0]   flags_out;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues: pushed when an operation is issued, popped on done.
  logic [W-1:0] exp_q[$];
  logic [3:0]   expf_q[$];

  // Model of architectural state.
  logic [W-1:0] model_result;
  logic [3:0]   model_flags;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operation (operation),
    .operand1  (operand1),
    .operand2  (operand2),
    .flags_we  (flags_we),
    .flags_in  (flags_in),
    .result    (result),
    .flags_out (flags_out),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic [3:0] f);
    longint unsigned la, lb, p, mask;
    logic c;
    la   = a;
    lb   = b;
    mask = (64'd1 << W) - 1;
    c    = model_flags[2];
    p    = la;
    case (op)
      3'd0: begin p = la + lb;          c = (p > mask); end
      3'd1: begin p = (la - lb) & mask; c = (la < lb);  end
      3'd2: p = la & lb;
      3'd3: p = la | lb;
      3'd4: p = (~la) & mask;
      3'd5: begin p = la + 1;           c = (p > mask); end
      3'd6: begin p = la * lb;          c = ((p >> W) != 0); end
      default: p = la;
    endcase
    r = W'(p & mask);
    f = {1'b0, c, r[W-1], (r == '0)};
  endtask

  task automatic scoreboard_pop(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      check({tag, "_result"}, result, exp_q.pop_front());
      check({tag, "_flags"}, flags_out, expf_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  // All drives and samples happen at the falling edge.
  task automatic run_single(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic we, input logic [3:0] fin);
    logic [W-1:0] r;
    logic [3:0]   f;
    model_op(op, a, b, r, f);
    exp_q.push_back(r);
    expf_q.push_back(f);
    model_result = r;
    model_flags  = f;          // completion beats flags_we
    start     = 1'b1;
    operation = op;
    operand1  = a;
    operand2  = b;
    flags_we  = we;
    flags_in  = fin;
    @(negedge clk);
    start    = 1'b0;
    flags_we = 1'b0;
    check("single_done", done, 1'b1);
    check("single_busy", busy, 1'b0);
    scoreboard_pop("single");
    @(negedge clk);
    check("single_done_drop", done, 1'b0);
    check("single_hold_result", result, model_result);
    check("single_hold_flags", flags_out, model_flags);
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic we, input logic [3:0] fin, input bit stray);
    logic [W-1:0] r;
    logic [3:0]   f;
    int busy_cycles;
    model_op(3'd6, a, b, r, f);
    exp_q.push_back(r);
    expf_q.push_back(f);
    start     = 1'b1;
    operation = 3'd6;
    operand1  = a;
    operand2  = b;
    flags_we  = we;
    flags_in  = fin;
    @(negedge clk);
    start    = 1'b0;
    flags_we = 1'b0;
    if (we) model_flags = {1'b0, fin[2:0]};   // no completion at acceptance
    check("mul_accept_busy", busy, 1'b1);
    check("mul_accept_flags", flags_out, model_flags);
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 2 * W + 4) begin
      check("mul_no_early_done", done, 1'b0);
      busy_cycles++;
      if (stray && $urandom_range(0, 2) == 0) begin
        start     = 1'b1;
        operation = 3'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
      operand1 = W'($urandom);
      operand2 = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    model_result = r;
    model_flags  = f;
    check("mul_busy_cycles", busy_cycles, W);
    check("mul_done", done, 1'b1);
    check("mul_busy_clear", busy, 1'b0);
    scoreboard_pop("mul");
    @(negedge clk);
    check("mul_done_drop", done, 1'b0);
    check("mul_idle", busy, 1'b0);
  endtask

  task automatic flags_load(input logic [3:0] fin);
    flags_we = 1'b1;
    flags_in = fin;
    @(negedge clk);
    flags_we    = 1'b0;
    model_flags = {1'b0, fin[2:0]};
    check("fload_flags", flags_out, model_flags);
    check("fload_no_done", done, 1'b0);
    check("fload_result_hold", result, model_result);
  endtask

  task automatic run_any(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic we, input logic [3:0] fin);
    if (op == 3'd6) run_mul(a, b, we, fin, 1'b1);
    else            run_single(op, a, b, we, fin);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'(1);
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; operation = '0; operand1 = '0; operand2 = '0;
    flags_we = 1'b0; flags_in = '0;
    model_result = '0;
    model_flags  = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result, 16'h0000);
    check("reset_flags", flags_out, 4'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // ADD with no carry, then wrapping ADD.
    run_single(3'd0, 16'h0FFE, 16'h0000, 1'b0, 4'h0);
    check("add1_value", model_result, 16'h0FFE);
    check("add1_flags_tbl", model_flags, 4'b0000);
    run_single(3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 4'h0);
    run_single(3'd0, 16'hFFFF, 16'h0001, 1'b0, 4'h0);
    check("add_wrap_z_c", flags_out, 4'b0101);

    // SUB equal and borrow.
    run_single(3'd1, 16'hFFFF, 16'hFFFF, 1'b0, 4'h0);
    check("sub_eq_flags", flags_out, 4'b0001);
    run_single(3'd1, 16'h0FFE, 16'h0FFF, 1'b0, 4'h0);
    check("sub_borrow_result", result, 16'hFFFF);
    check("sub_borrow_flags", flags_out, 4'b0110);

    // Logical ops keep carry.
    run_single(3'd2, 16'h00F0, 16'h0F0F, 1'b0, 4'h0);
    check("and_keep_c", flags_out, 4'b0101);

    // MUL overflow, with stray starts during busy.
    run_mul(16'h0100, 16'h0100, 1'b0, 4'h0, 1'b1);
    check("mul_ovf_result", result, 16'h0000);
    check("mul_ovf_flags", flags_out, 4'b0101);
    run_mul(16'h00FF, 16'h0003, 1'b0, 4'h0, 1'b1);
    check("mul_small_result", result, 16'h02FD);
    check("mul_small_flags", flags_out, 4'b0000);

    // Reset during a multiply.
    start = 1'b1; operation = 3'd6; operand1 = 16'h1234; operand2 = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_result", result, 16'h0000);
    check("rst_mid_flags", flags_out, 4'h0);
    check("rst_mid_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_result = '0;
    model_flags  = '0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("rst_no_done", done, 1'b0);
    end
    run_single(3'd0, 16'h0001, 16'h0001, 1'b0, 4'h0);
    check("post_rst_add", result, 16'h0002);

    // Flag register load and priority against completion.
    flags_load(4'b1111);
    check("fload_0111", flags_out, 4'b0111);
    run_single(3'd0, 16'h0001, 16'h0001, 1'b1, 4'b1111);
    check("fload_vs_add", flags_out, 4'b0000);

    // Randomized operations.
    for (int n = 0; n < 60; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) flags_load(4'($urandom));
      run_any(op, rand_operand(), rand_operand(),
              ($urandom_range(0, 3) == 0), 4'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("idle_hold_result", result, model_result);
        check("idle_hold_flags", flags_out, model_flags);
        check("idle_no_done", done, 1'b0);
      end
    end

    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Exclusivity of done and busy, checked every cycle.
  always @(negedge clk) begin
    if (!rst && done === 1'b1 && busy === 1'b1) begin
      check("done_busy_exclusive", {done, busy}, 2'b10);
    end
  end

  // Global safety net.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width (>= 4).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one operation, sampled only in IDLE.
REQ-005 SHALL have port operation  input  3  opcode (REQ-011).
REQ-006 SHALL have port operand1  input  WIDTH  first operand.
REQ-007 SHALL have port operand2  input  WIDTH  second operand.
REQ-008 SHALL have port flags_we, flags_in  input  1, 4  load the flag register from flags_in (context restore).
REQ-009 SHALL have port result  output  WIDTH  registered result of the last completed operation.
REQ-010 SHALL have port flags_out, busy, done  output  4, 1, 1  flag register; multi-cycle op in progress; one-cycle completion pulse.

Function
REQ-011 Opcodes SHALL be: 000 ADD, 001 SUB (op1-op2), 010 AND, 011 OR, 100 NOT op1, 101 INC op1, 110 MUL (unsigned, multi-cycle), 111 PASS op1.
REQ-012 Flags SHALL be: bit0 Z (result==0), bit1 N (result MSB), bit2 C, bit3 always 0.
REQ-013 C SHALL be: ADD/INC carry-out of bit WIDTH-1; SUB borrow (1 when op1<op2 unsigned); MUL 1 when the upper WIDTH product bits are nonzero; AND/OR/NOT/PASS keep the previous C.
REQ-014 State machine SHALL have states IDLE and MUL; reset state IDLE.
REQ-015 IDLE, start=1, opcode != 110: at that same edge result and flags_out SHALL update and done SHALL be 1 for exactly the following cycle; state stays IDLE.
REQ-016 IDLE, start=1, opcode 110: operands SHALL be latched at that edge (edge k), busy SHALL go 1, state -> MUL.
REQ-017 MUL SHALL perform one shift-add step per cycle over a 2*WIDTH-bit accumulator; at edge k+WIDTH result = low WIDTH product bits, flags update, done=1 for one cycle, busy=0, state -> IDLE.
REQ-018 start while busy=1 SHALL be ignored; operand/opcode changes during MUL SHALL not affect the product.
REQ-019 result and flags_out SHALL hold their values between completions.
REQ-020 flags_we=1 SHALL load flags_in[2:0] into flags_out at the edge, bit3 forced 0; at an edge where an operation completes, the operation's flag update SHALL take priority.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; ADD 0xFFFF+0x0001 (WIDTH=16) wraps to 0x0000 with C=1, Z=1.
REQ-022 done and busy SHALL never both be 1 in the same cycle.

Reset
REQ-023 rst=1 SHALL asynchronously force state IDLE, result=0, flags_out=0000, busy=0, done=0, accumulator cleared.
REQ-024 rst asserted mid-MUL SHALL abort the operation with no done pulse; first start after release SHALL be accepted normally.

Verification
REQ-025 ADD 0x0FFE+0x0000 then ADD 0xFFFF+0xFFFF -> result 0x0FFE flags 0000, then 0xFFFE flags 0110, done one cycle each.
REQ-026 SUB 0xFFFF-0xFFFF -> 0x0000 flags 0001; SUB 0x0FFE-0x0FFF -> 0xFFFF flags 0110.
REQ-027 MUL 0x0100*0x0100 -> busy 16 cycles, then result 0x0000 flags 0101, done 1 cycle; start pulsed during busy produces no extra done.
REQ-028 MUL 0x00FF*0x0003 -> result 0x02FD flags 0000 after 16 cycles.
REQ-029 rst asserted at cycle 5 of a MUL -> immediately busy=0, result 0, flags 0000, no done; next ADD 1+1 -> 0x0002.
REQ-030 flags_we with flags_in=1111 in IDLE -> flags_out 0111; flags_we coinciding with ADD 1+1 completion -> flags_out 0000.
